// File: rtl/fp32_addsub_seq_if.sv
// Handshake and operand/result bundle for the sequential fp32 add/sub unit.
// master drives operands and accepts results; slave is the arithmetic unit.
interface fp32_addsub_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic             op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             overflow_o;
  logic             invalid_o;

  modport master (
    output in_valid_i, op_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, overflow_o, invalid_o
  );

  modport slave (
    input  in_valid_i, op_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, overflow_o, invalid_o
  );
endinterface

// File: rtl/fp32_addsub_seq.sv
// Multi-cycle fp32 adder/subtractor: one operation in flight, fixed 5-cycle latency,
// round-to-nearest-even, denormals flushed to zero on input and output.
module fp32_addsub_seq #(
  parameter int WIDTH    = 32,
  parameter int GRS_BITS = 3
) (
  input logic                clk_i,
  input logic                rst_ni,
  fp32_addsub_seq_if.slave   bus
);

  localparam int MW  = 24 + GRS_BITS;
  localparam int LZW = $clog2(MW + 1);

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
  } state_t;

  state_t state_reg, state_next;

  // Stage registers
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             op_reg;
  logic             x_sign_reg, y_sign_reg;
  logic [7:0]       x_exp_reg, y_exp_reg;
  logic [23:0]      x_mant_reg, y_mant_reg;
  logic             spec_valid_reg, spec_invalid_reg;
  logic [WIDTH-1:0] spec_result_reg;
  logic [MW-1:0]    x_ext_reg, y_al_reg;
  logic [MW:0]      sum_reg;
  logic [MW-1:0]    norm_mant_reg;
  logic signed [9:0] norm_exp_reg;
  logic             norm_zero_reg, norm_sign_reg;
  logic [WIDTH-1:0] result_reg;
  logic             overflow_reg, invalid_reg;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid_i) state_next = UNPACK;
      UNPACK:  state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (bus.out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready_o  = (state_reg == IDLE);
    bus.out_valid_o = (state_reg == DONE);
  end

  assign bus.result_o   = result_reg;
  assign bus.overflow_o = overflow_reg;
  assign bus.invalid_o  = invalid_reg;

  // ---------------- UNPACK ----------------
  logic [7:0]  a_exp, b_exp;
  logic        a_sign, b_sign_eff;
  logic [30:0] a_mag, b_mag;
  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic        spec_valid_next, spec_invalid_next;
  logic [WIDTH-1:0] spec_result_next;

  always_comb begin
    a_exp      = a_reg[30:23];
    b_exp      = b_reg[30:23];
    a_sign     = a_reg[31];
    b_sign_eff = b_reg[31] ^ op_reg;
    a_mag      = (a_exp == 8'd0) ? 31'd0 : a_reg[30:0];
    b_mag      = (b_exp == 8'd0) ? 31'd0 : b_reg[30:0];
    a_nan      = (&a_exp) && (|a_reg[22:0]);
    b_nan      = (&b_exp) && (|b_reg[22:0]);
    a_inf      = (&a_exp) && !(|a_reg[22:0]);
    b_inf      = (&b_exp) && !(|b_reg[22:0]);
    swap       = (b_mag > a_mag);

    // Specials resolved up front; ROUND picks them over the arithmetic path.
    spec_valid_next   = 1'b1;
    spec_invalid_next = 1'b0;
    spec_result_next  = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign_eff))) begin
      spec_result_next  = 32'h7FC0_0000;
      spec_invalid_next = 1'b1;
    end else if (a_inf) begin
      spec_result_next = {a_sign, a_reg[30:0]};
    end else if (b_inf) begin
      spec_result_next = {b_sign_eff, b_reg[30:0]};
    end else if (a_mag == 31'd0 && b_mag == 31'd0) begin
      spec_result_next = {a_sign & b_sign_eff, 31'd0};
    end else if (b_mag == 31'd0) begin
      spec_result_next = {a_sign, a_mag};
    end else if (a_mag == 31'd0) begin
      spec_result_next = {b_sign_eff, b_mag};
    end else begin
      spec_valid_next = 1'b0;
    end
  end

  // ---------------- ALIGN ----------------
  logic [7:0]      shift_d;
  logic [MW-1:0]   y_ext;
  logic [2*MW-1:0] y_wide;
  logic [MW-1:0]   y_al_next;

  always_comb begin
    shift_d = x_exp_reg - y_exp_reg;
    y_ext   = {y_mant_reg, {GRS_BITS{1'b0}}};
    y_wide  = {y_ext, {MW{1'b0}}} >> shift_d;
    if (shift_d >= 8'(MW))
      y_al_next = {{(MW-1){1'b0}}, |y_mant_reg};
    else
      y_al_next = {y_wide[2*MW-1:MW+1], y_wide[MW] | (|y_wide[MW-1:0])};
  end

  // ---------------- ADD ----------------
  logic [MW:0] sum_next;

  always_comb begin
    if (x_sign_reg ^ y_sign_reg) sum_next = {1'b0, x_ext_reg} - {1'b0, y_al_reg};
    else                         sum_next = {1'b0, x_ext_reg} + {1'b0, y_al_reg};
  end

  // ---------------- NORM ----------------
  logic [LZW-1:0]    lzc;
  logic [MW-1:0]     norm_mant_next;
  logic signed [9:0] norm_exp_next;
  logic              norm_zero_next, norm_sign_next;

  always_comb begin
    lzc = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (sum_reg[i]) lzc = LZW'(MW - 1 - i);
    end

    norm_sign_next = x_sign_reg;
    norm_zero_next = 1'b0;
    if (sum_reg[MW]) begin
      norm_mant_next = {sum_reg[MW:2], sum_reg[1] | sum_reg[0]};
      norm_exp_next  = $signed({2'b00, x_exp_reg}) + 10'sd1;
    end else begin
      norm_mant_next = sum_reg[MW-1:0] << lzc;
      norm_exp_next  = $signed({2'b00, x_exp_reg}) - $signed({{(10-LZW){1'b0}}, lzc});
    end

    if (sum_reg == '0) begin
      norm_zero_next = 1'b1;
      norm_sign_next = 1'b0;
    end else if (norm_exp_next <= 10'sd0) begin
      norm_zero_next = 1'b1;
    end
  end

  // ---------------- ROUND ----------------
  logic [23:0]       kept;
  logic              guard, round_sticky, round_up;
  logic [24:0]       rounded;
  logic signed [9:0] exp_r;
  logic [22:0]       frac_r;
  logic [WIDTH-1:0]  result_next;
  logic              overflow_next, invalid_next;

  always_comb begin
    kept         = norm_mant_reg[MW-1:GRS_BITS];
    guard        = norm_mant_reg[GRS_BITS-1];
    round_sticky = |norm_mant_reg[GRS_BITS-2:0];
    round_up     = guard && (round_sticky || kept[0]);
    rounded      = {1'b0, kept} + {24'd0, round_up};
    exp_r        = norm_exp_reg + (rounded[24] ? 10'sd1 : 10'sd0);
    frac_r       = rounded[24] ? 23'd0 : rounded[22:0];

    overflow_next = 1'b0;
    invalid_next  = 1'b0;
    if (spec_valid_reg) begin
      result_next  = spec_result_reg;
      invalid_next = spec_invalid_reg;
    end else if (norm_zero_reg) begin
      result_next = {norm_sign_reg, 31'd0};
    end else if (exp_r >= 10'sd255) begin
      result_next   = {norm_sign_reg, 31'h7F80_0000};
      overflow_next = 1'b1;
    end else begin
      result_next = {norm_sign_reg, exp_r[7:0], frac_r};
    end
  end

  // Pipeline-stage datapath; contents only matter while the FSM walks the stages.
  always_ff @(posedge clk_i) begin
    case (state_reg)
      IDLE: begin
        if (bus.in_valid_i) begin
          a_reg  <= bus.a_i;
          b_reg  <= bus.b_i;
          op_reg <= bus.op_i;
        end
      end
      UNPACK: begin
        x_sign_reg       <= swap ? b_sign_eff : a_sign;
        y_sign_reg       <= swap ? a_sign : b_sign_eff;
        x_exp_reg        <= swap ? b_mag[30:23] : a_mag[30:23];
        y_exp_reg        <= swap ? a_mag[30:23] : b_mag[30:23];
        x_mant_reg       <= swap ? {|b_mag, b_mag[22:0]} : {|a_mag, a_mag[22:0]};
        y_mant_reg       <= swap ? {|a_mag, a_mag[22:0]} : {|b_mag, b_mag[22:0]};
        spec_valid_reg   <= spec_valid_next;
        spec_invalid_reg <= spec_invalid_next;
        spec_result_reg  <= spec_result_next;
      end
      ALIGN: begin
        x_ext_reg <= {x_mant_reg, {GRS_BITS{1'b0}}};
        y_al_reg  <= y_al_next;
      end
      ADD: sum_reg <= sum_next;
      NORM: begin
        norm_mant_reg <= norm_mant_next;
        norm_exp_reg  <= norm_exp_next;
        norm_zero_reg <= norm_zero_next;
        norm_sign_reg <= norm_sign_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      invalid_reg  <= 1'b0;
    end else if (state_reg == ROUND) begin
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      invalid_reg  <= invalid_next;
    end
  end

endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Directed bench for fp32_addsub_seq: arithmetic vectors, specials, latency,
// backpressure, busy-time input rejection and mid-operation reset.
module tb_fp32_addsub_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp32_addsub_seq_if #(.WIDTH(32)) bus ();

  fp32_addsub_seq #(.WIDTH(32), .GRS_BITS(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_ovf, input logic exp_inv);
    int cyc;
    check({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
    bus.op_i        = op;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b0;
    tick();
    bus.in_valid_i = 1'b0;
    cyc = 0;
    while (bus.out_valid_o !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd5);
    check({tag, "_result"}, bus.result_o, exp_res);
    check({tag, "_overflow"}, 32'(bus.overflow_o), 32'(exp_ovf));
    check({tag, "_invalid"}, 32'(bus.invalid_o), 32'(exp_inv));
    $display("txn %s op=%0d a=%h b=%h result=%h ovf=%0b inv=%0b", tag, op, a, b,
             bus.result_o, bus.overflow_o, bus.invalid_o);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid_o), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.in_ready_o), 32'd1);
  endtask

  initial begin
    int cyc;
    logic seen;

    rst_n           = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.op_i        = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.out_ready_i = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);
    check("rst_invalid", 32'(bus.invalid_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Arithmetic, rounding and special vectors
    run_op("add_1_1",     1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    run_op("add_25_25",   1'b0, 32'h40200000, 32'h40200000, 32'h40A00000, 1'b0, 1'b0);
    run_op("sub_2_1",     1'b1, 32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    run_op("sub_1_1",     1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
    run_op("sub_1_3",     1'b1, 32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 1'b0);
    run_op("rnd_tie",     1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0);
    run_op("rnd_up",      1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 1'b0, 1'b0);
    run_op("denorm_ftz",  1'b0, 32'h3F800000, 32'h00000001, 32'h3F800000, 1'b0, 1'b0);
    run_op("ovf_max",     1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
    run_op("inf_m_inf",   1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1);
    run_op("ninf_p_1",    1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0);

    // Backpressure plus operands offered while busy
    bus.op_i        = 1'b0;
    bus.a_i         = 32'h3F800000;
    bus.b_i         = 32'h3F800000;
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b0;
    tick();
    bus.a_i = 32'h40400000;
    bus.b_i = 32'h40400000;
    check("busy_in_ready", 32'(bus.in_ready_o), 32'd0);
    tick();
    bus.in_valid_i = 1'b0;
    cyc = 0;
    while (bus.out_valid_o !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("bp_latency", 32'(cyc), 32'd4);
    check("bp_result", bus.result_o, 32'h40000000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", 32'(bus.out_valid_o), 32'd1);
      check("bp_hold_result", bus.result_o, 32'h40000000);
      check("bp_hold_in_ready", 32'(bus.in_ready_o), 32'd0);
    end
    $display("txn backpressure result=%h", bus.result_o);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check("bp_valid_drop", 32'(bus.out_valid_o), 32'd0);
    check("bp_ready_back", 32'(bus.in_ready_o), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid_o !== 1'b0) seen = 1'b1;
    end
    check("busy_ops_ignored", 32'(seen), 32'd0);
    check("idle_result_held", bus.result_o, 32'h40000000);

    // Reset while the operation is in ALIGN
    bus.a_i        = 32'h40200000;
    bus.b_i        = 32'h40200000;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("midrst_result", bus.result_o, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid_o !== 1'b0) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    $display("txn midop_reset out_valid_seen=%0b", seen);

    run_op("post_rst",    1'b0, 32'h40200000, 32'h40200000, 32'h40A00000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
